// File: rtl/whack_mole_engine.sv
// Whack-a-mole game engine: LFSR-placed moles, per-mole countdown, score/strike tracking.
// Latency: all outputs registered; a switch event is reflected one clk after it is sampled.
// Backpressure: none; start is honoured only in IDLE/DONE, switches only while ACTIVE.
module whack_mole_engine #(
    parameter int N_MOLES       = 10,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int ROUND_SEC     = 5,
    parameter int MIN_SEC       = 2,
    parameter int MAX_MISSES    = 3,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] mole_led,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         sec_left,
    output logic [2:0]         misses,
    output logic               hit,
    output logic               game_over
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int IDX_W  = $clog2(N_MOLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         lfsr;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    idx_nxt;
    logic [N_MOLES-1:0]  baseline;
    logic [N_MOLES-1:0]  diff;
    logic [N_MOLES-1:0]  led_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [3:0]          cur_sec;
    logic                is_hit;
    logic                is_miss;
    logic                tick_wrap;
    logic                timeout;
    logic                last_strike;
    logic                fb;

    // Event decode and next-state selection
    always_comb begin
        state_nxt   = state;
        diff        = sw ^ baseline;
        is_hit      = 1'b0;
        is_miss     = 1'b0;
        tick_wrap   = (tick_cnt == TICK_W'(TICKS_PER_SEC - 1));
        timeout     = 1'b0;
        last_strike = (misses == 3'(MAX_MISSES - 1));
        fb          = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        cand        = IDX_W'(lfsr % 16'(N_MOLES));
        pick        = cand;
        if (cand == idx) begin
            pick = (cand == IDX_W'(N_MOLES - 1)) ? '0 : cand + 1'b1;
        end
        idx_nxt = idx;
        if (state == ARM) begin
            idx_nxt = pick;
        end
        if (state == ACTIVE) begin
            is_hit  = (diff == mole_led);
            is_miss = |(diff & ~mole_led);
            timeout = tick_wrap && (sec_left == 4'd1);
        end

        case (state)
            IDLE: begin
                if (start) state_nxt = ARM;
            end
            ARM: begin
                state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (is_hit) begin
                    state_nxt = ARM;
                end else if ((is_miss && last_strike) || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) state_nxt = ARM;
            end
            default: state_nxt = IDLE;
        endcase

        led_nxt = '0;
        if (state_nxt == ACTIVE) begin
            led_nxt = {{(N_MOLES-1){1'b0}}, 1'b1} << idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= 16'hACE1;
            idx       <= '0;
            baseline  <= '0;
            tick_cnt  <= '0;
            cur_sec   <= 4'(ROUND_SEC);
            mole_led  <= '0;
            score     <= '0;
            sec_left  <= '0;
            misses    <= '0;
            hit       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            // The LFSR free-runs so mole placement depends on player timing
            lfsr      <= {lfsr[14:0], fb};
            idx       <= idx_nxt;
            mole_led  <= led_nxt;
            hit       <= is_hit;
            game_over <= (state_nxt == DONE);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score   <= '0;
                        misses  <= '0;
                        cur_sec <= 4'(ROUND_SEC);
                    end
                end
                ARM: begin
                    baseline <= sw;
                    sec_left <= cur_sec;
                    tick_cnt <= '0;
                end
                ACTIVE: begin
                    if (is_hit) begin
                        if (score != '1) score <= score + 1'b1;
                        cur_sec <= (cur_sec > 4'(MIN_SEC)) ? cur_sec - 1'b1 : 4'(MIN_SEC);
                    end else begin
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                        if (tick_wrap) sec_left <= sec_left - 1'b1;
                        // A wrong flip is forgiven by re-baselining so it counts once
                        if (is_miss) begin
                            misses   <= misses + 1'b1;
                            baseline <= sw;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
